user_module_cpu: RTL and testbench

- Minimal 2-register, 6-bit accumulator CPU for a TinyTapeout-style 8-in/8-out user slot.
- Clock, reset and 6-bit instruction/data bus come in on io_in.
- The 6-bit program address goes out on io_out[5:0]; program memory is external and combinational (data valid on io_in[7:2] for the current address).
- Each instruction takes 2 clocks: fetch, then execute/operand.

---
 rtl/user_module_cpu.sv | 79 +++++++
 tb/tb_user_module_cpu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/user_module_cpu.sv
// Two-register 6-bit accumulator CPU for an 8-in/8-out pad slot; every instruction is fetch + execute.
// Define SUB_EN to decode opcode 7 as SUB (reg_a - reg_b); without it opcode 7 is a NOP.
module user_module_cpu (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } phase_t;

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SWAP = 6'd2,
        OP_JMP  = 6'd3,
        OP_JZ   = 6'd4,
        OP_LDA  = 6'd5,
        OP_LDB  = 6'd6,
        OP_SUB  = 6'd7
    } opcode_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] data;

    logic [5:0] reg_a;
    logic [5:0] reg_b;
    logic [5:0] pc;
    logic [5:0] instr;
    phase_t     micro_pc;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign data  = io_in[7:2];

    // All outputs come straight from state; no path from io_in to io_out.
    assign io_out = {(reg_a == '0), micro_pc, pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a    <= '0;
            reg_b    <= '0;
            pc       <= '0;
            instr    <= '0;
            micro_pc <= FETCH;
        end else if (micro_pc == FETCH) begin
            instr    <= data;
            pc       <= pc + 6'd1;
            micro_pc <= EXEC;
        end else begin
            micro_pc <= FETCH;
            // Two-word opcodes read their operand from the word at the current pc.
            case (instr)
                OP_ADD:  reg_a <= reg_a + reg_b;
                OP_SWAP: begin
                    reg_a <= reg_b;
                    reg_b <= reg_a;
                end
                OP_JMP:  pc <= data;
                OP_JZ:   pc <= (reg_a == '0) ? data : pc + 6'd1;
                OP_LDA:  begin
                    reg_a <= data;
                    pc    <= pc + 6'd1;
                end
                OP_LDB:  begin
                    reg_b <= data;
                    pc    <= pc + 6'd1;
                end
`ifdef SUB_EN
                OP_SUB:  reg_a <= reg_a - reg_b;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_user_module_cpu.sv
// Scoreboard bench for user_module_cpu: a cycle model predicts state each clock, results are compared after the edge.
module tb_user_module_cpu;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] pc;
        logic [5:0] instr;
        logic       upc;
    } st_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] mem [64];
    logic [7:0] io_in;
    logic [7:0] io_out;

    int unsigned n_checks;
    int unsigned n_errors;

    st_t m;
    st_t exp_q [$];

    assign io_in = {mem[io_out[5:0]], rst_n, clk};

    user_module_cpu dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic st_t model_next(input st_t s, input logic rst, input logic [5:0] d);
        st_t n;
        n = s;
        if (!rst) begin
            n = '0;
        end else if (!s.upc) begin
            n.instr = d;
            n.pc    = s.pc + 6'd1;
            n.upc   = 1'b1;
        end else begin
            n.upc = 1'b0;
            case (s.instr)
                6'd1: n.a = s.a + s.b;
                6'd2: begin n.a = s.b; n.b = s.a; end
                6'd3: n.pc = d;
                6'd4: n.pc = (s.a == 6'd0) ? d : s.pc + 6'd1;
                6'd5: begin n.a = d; n.pc = s.pc + 6'd1; end
                6'd6: begin n.b = d; n.pc = s.pc + 6'd1; end
`ifdef SUB_EN
                6'd7: n.a = s.a - s.b;
`endif
                default: ;
            endcase
        end
        return n;
    endfunction

    task automatic step();
        st_t e;
        @(negedge clk);
        m = model_next(m, rst_n, mem[m.pc]);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("reg_a",    {26'd0, dut.reg_a}, {26'd0, e.a});
            check("reg_b",    {26'd0, dut.reg_b}, {26'd0, e.b});
            check("pc",       {26'd0, dut.pc},    {26'd0, e.pc});
            check("instr",    {26'd0, dut.instr}, {26'd0, e.instr});
            check("micro_pc", {31'd0, dut.micro_pc}, {31'd0, e.upc});
            check("io_out",   {24'd0, io_out}, {24'd0, (e.a == 6'd0), e.upc, e.pc});
        end
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic fill_mem(input logic [5:0] base, input logic use_pattern);
        for (int unsigned i = 0; i < 64; i++)
            mem[i] = use_pattern ? (base + 6'(i & 3)) : base;
    endtask

    // Assert async reset away from the clock edge, check immediately, hold two clocks.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_io_out", {24'd0, io_out}, 32'h80);
        check("rst_reg_a",  {26'd0, dut.reg_a}, 32'd0);
        check("rst_reg_b",  {26'd0, dut.reg_b}, 32'd0);
        check("rst_pc",     {26'd0, dut.pc}, 32'd0);
        check("rst_instr",  {26'd0, dut.instr}, 32'd0);
        check("rst_upc",    {31'd0, dut.micro_pc}, 32'd0);
        m = '0;
        exp_q.delete();
        steps(2);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        m        = '0;
        fill_mem(6'd0, 1'b0);
        #2;

        // Program loop: ADD, SWAP, JZ 0 (taken with reg_a = 0).
        apply_reset();
        fill_mem(6'd60, 1'b1);
        mem[0] = 6'd1; mem[1] = 6'd2; mem[2] = 6'd4;
        mem[3] = 6'd0; mem[4] = 6'd3; mem[5] = 6'd4;
        release_reset();
        steps(5);
        check("loop_pc_before_jz", {26'd0, dut.pc}, 32'd3);
        step();
        check("loop_jz_taken_pc", {26'd0, dut.pc}, 32'd0);
        steps(6);
        check("loop_reg_a_zero", {26'd0, dut.reg_a}, 32'd0);

        // LDA 5, LDB 7, ADD, SWAP.
        apply_reset();
        fill_mem(6'd0, 1'b0);
        mem[0] = 6'd5; mem[1] = 6'd5; mem[2] = 6'd6; mem[3] = 6'd7;
        mem[4] = 6'd1; mem[5] = 6'd2;
        release_reset();
        steps(2);
        check("lda_zflag", {31'd0, io_out[7]}, 32'd0);
        steps(4);
        check("add_reg_a", {26'd0, dut.reg_a}, 32'd12);
        check("add_reg_b", {26'd0, dut.reg_b}, 32'd7);
        steps(2);
        check("swap_reg_a", {26'd0, dut.reg_a}, 32'd7);
        check("swap_reg_b", {26'd0, dut.reg_b}, 32'd12);
        check("swap_zflag", {31'd0, io_out[7]}, 32'd0);

        // Mid-run reset with non-zero state.
        steps(1);
        apply_reset();

        // JZ not taken: reg_a = 3, JZ 20 at address 8.
        fill_mem(6'd0, 1'b0);
        mem[0] = 6'd5; mem[1] = 6'd3; mem[2] = 6'd3; mem[3] = 6'd8;
        mem[8] = 6'd4; mem[9] = 6'd20; mem[10] = 6'd0; mem[20] = 6'd2;
        release_reset();
        steps(4);
        check("jmp_to_8", {26'd0, dut.pc}, 32'd8);
        steps(2);
        check("jz_not_taken_pc", {26'd0, dut.pc}, 32'd10);
        step();
        check("jz_next_fetch_pc", {26'd0, dut.pc}, 32'd11);
        check("jz_next_fetch_instr", {26'd0, dut.instr}, 32'd0);

        // JMP 63 then NOP at 63 wraps to 0, where ADD 40 + 40 gives 16.
        apply_reset();
        fill_mem(6'd0, 1'b0);
        mem[0]  = 6'd3;  mem[1]  = 6'd10;
        mem[10] = 6'd5;  mem[11] = 6'd40;
        mem[12] = 6'd6;  mem[13] = 6'd40;
        mem[14] = 6'd3;  mem[15] = 6'd63;
        mem[63] = 6'd0;
        release_reset();
        steps(2);
        mem[0] = 6'd1;
        steps(6);
        check("jmp_63_pc", {26'd0, dut.pc}, 32'd63);
        step();
        check("wrap_fetch_pc", {26'd0, dut.pc}, 32'd0);
        steps(3);
        check("wrap_add_reg_a", {26'd0, dut.reg_a}, 32'd16);

        // Opcode 7 with reg_a = 2, reg_b = 5.
        apply_reset();
        fill_mem(6'd0, 1'b0);
        mem[0] = 6'd5; mem[1] = 6'd2; mem[2] = 6'd6; mem[3] = 6'd5;
        mem[4] = 6'd7;
        release_reset();
        steps(6);
`ifdef SUB_EN
        check("op7_reg_a", {26'd0, dut.reg_a}, 32'd61);
`else
        check("op7_reg_a", {26'd0, dut.reg_a}, 32'd2);
`endif
        check("op7_pc", {26'd0, dut.pc}, 32'd5);
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
